// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: IM port, hazard/redirect inputs and IF/ID outputs.
// master is the fetch stage; slave is the IM/decode/EX side.
interface instr_fetch_if;
  logic        stall_IF_ID;
  logic        flow_change_ID_EX;
  logic [15:0] dst_ID_EX;
  logic [15:0] instr;
  logic [15:0] iaddr;
  logic        rd_en;
  logic [15:0] instr_IF_ID;
  logic [15:0] pc_IF_ID;
  logic        valid_IF_ID;
  logic        halted;
  logic [15:0] fetch_cnt;

  modport master (
    input  stall_IF_ID, flow_change_ID_EX, dst_ID_EX, instr,
    output iaddr, rd_en, instr_IF_ID, pc_IF_ID, valid_IF_ID,
    output halted, fetch_cnt
  );

  modport slave (
    output stall_IF_ID, flow_change_ID_EX, dst_ID_EX, instr,
    input  iaddr, rd_en, instr_IF_ID, pc_IF_ID, valid_IF_ID,
    input  halted, fetch_cnt
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives IM, loads the IF/ID register.
// Handles decode stalls, EX redirects and HLT detection.
module instr_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'hB000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input logic clk,
  input logic rst,
  instr_fetch_if.master bus
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [15:0] instr_q;
  logic [15:0] pc_q;
  logic        valid_q;
  logic [15:0] cnt_q;
  logic        is_hlt;
  logic        flow;
  logic        stall;
  logic        halted_o;
  logic        rd_en_o;

  assign flow   = bus.flow_change_ID_EX;
  assign stall  = bus.stall_IF_ID;
  assign pc_inc = pc + 16'd1;
  assign is_hlt = (bus.instr[15:12] == HLT_OPCODE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  // Next state: a fetched HLT parks fetch; only a redirect restarts it.
  always_comb begin
    state_n = state;
    unique case (state)
      RUN:    if (!flow && !stall && is_hlt) state_n = HALTED;
      HALTED: if (flow) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Outputs of the FSM: halt flag and IM read enable.
  always_comb begin
    halted_o = 1'b0;
    rd_en_o  = 1'b0;
    unique case (state)
      RUN:     rd_en_o  = ~stall & ~rst;
      HALTED:  halted_o = 1'b1;
      default: rd_en_o  = 1'b0;
    endcase
  end

  // PC and IF/ID register: redirect beats stall beats normal fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc_q    <= 16'h0000;
      valid_q <= 1'b0;
      cnt_q   <= 16'h0000;
    end else if (flow) begin
      pc      <= bus.dst_ID_EX;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (stall) begin
      pc      <= pc;
    end else if (state == RUN) begin
      instr_q <= bus.instr;
      pc_q    <= pc_inc;
      valid_q <= 1'b1;
      cnt_q   <= cnt_q + 16'd1;
      if (!is_hlt) pc <= pc_inc;
    end else begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end
  end

  assign bus.iaddr       = pc;
  assign bus.rd_en       = rd_en_o;
  assign bus.halted      = halted_o;
  assign bus.instr_IF_ID = instr_q;
  assign bus.pc_IF_ID    = pc_q;
  assign bus.valid_IF_ID = valid_q;
  assign bus.fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a negedge-latching IM model.
// Checks sampled 1 time unit after each rising edge.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [15:0] mem [0:65535];

  instr_fetch_if bus ();

  instr_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Instruction memory: latches on clk low when enabled.
  always @(negedge clk) begin
    if (bus.rd_en) bus.instr <= mem[bus.iaddr];
  end

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag,
                          input logic [15:0] ia,
                          input logic [15:0] ins,
                          input logic [15:0] pcq,
                          input logic        v,
                          input logic [15:0] cnt);
    chk({tag, ".iaddr"}, bus.iaddr, ia);
    chk({tag, ".instr"}, bus.instr_IF_ID, ins);
    chk({tag, ".pc"},    bus.pc_IF_ID, pcq);
    chk({tag, ".valid"}, {15'd0, bus.valid_IF_ID}, {15'd0, v});
    chk({tag, ".cnt"},   bus.fetch_cnt, cnt);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = i[15:0];
      mem[i] = {4'h1, a[11:0]};
    end
    mem[5] = 16'hF000;
    bus.stall_IF_ID       = 1'b0;
    bus.flow_change_ID_EX = 1'b0;
    bus.dst_ID_EX         = 16'h0000;
    bus.instr             = 16'h0000;

    step();
    chk_ifid("rst", 16'h0000, 16'hB000, 16'h0000, 1'b0, 16'd0);
    chk("rst.rd_en", {15'd0, bus.rd_en}, 16'd0);
    chk("rst.halted", {15'd0, bus.halted}, 16'd0);
    rst = 1'b0;

    step(); chk_ifid("run1", 16'd1, 16'h1000, 16'd1, 1'b1, 16'd1);
    step(); chk_ifid("run2", 16'd2, 16'h1001, 16'd2, 1'b1, 16'd2);
    step(); chk_ifid("run3", 16'd3, 16'h1002, 16'd3, 1'b1, 16'd3);

    bus.stall_IF_ID = 1'b1;
    #1;
    chk("stall.rd_en", {15'd0, bus.rd_en}, 16'd0);
    step(); chk_ifid("stall1", 16'd3, 16'h1002, 16'd3, 1'b1, 16'd3);
    step(); chk_ifid("stall2", 16'd3, 16'h1002, 16'd3, 1'b1, 16'd3);
    bus.stall_IF_ID = 1'b0;

    step(); chk_ifid("resume1", 16'd4, 16'h1003, 16'd4, 1'b1, 16'd4);
    step(); chk_ifid("resume2", 16'd5, 16'h1004, 16'd5, 1'b1, 16'd5);

    step(); chk_ifid("hlt", 16'd5, 16'hF000, 16'd6, 1'b1, 16'd6);
    chk("hlt.halted", {15'd0, bus.halted}, 16'd1);
    chk("hlt.rd_en", {15'd0, bus.rd_en}, 16'd0);
    step(); chk_ifid("halt1", 16'd5, 16'hB000, 16'd6, 1'b0, 16'd6);
    step(); chk_ifid("halt2", 16'd5, 16'hB000, 16'd6, 1'b0, 16'd6);
    chk("halt2.halted", {15'd0, bus.halted}, 16'd1);

    bus.flow_change_ID_EX = 1'b1;
    bus.dst_ID_EX         = 16'h0010;
    step(); chk_ifid("unhalt", 16'h0010, 16'hB000, 16'd6, 1'b0, 16'd6);
    chk("unhalt.halted", {15'd0, bus.halted}, 16'd0);
    bus.flow_change_ID_EX = 1'b0;
    #1;
    chk("unhalt.rd_en", {15'd0, bus.rd_en}, 16'd1);
    step(); chk_ifid("unhalt.f", 16'h0011, 16'h1010, 16'h0011, 1'b1, 16'd7);

    bus.flow_change_ID_EX = 1'b1;
    bus.stall_IF_ID       = 1'b1;
    bus.dst_ID_EX         = 16'h0040;
    step(); chk_ifid("redir", 16'h0040, 16'hB000, 16'h0011, 1'b0, 16'd7);
    bus.flow_change_ID_EX = 1'b0;
    bus.stall_IF_ID       = 1'b0;
    step(); chk_ifid("redir.f", 16'h0041, 16'h1040, 16'h0041, 1'b1, 16'd8);

    bus.flow_change_ID_EX = 1'b1;
    bus.dst_ID_EX         = 16'hFFFF;
    step(); chk_ifid("wrap0", 16'hFFFF, 16'hB000, 16'h0041, 1'b0, 16'd8);
    bus.flow_change_ID_EX = 1'b0;
    step(); chk_ifid("wrap1", 16'h0000, 16'h1FFF, 16'h0000, 1'b1, 16'd9);
    step(); chk_ifid("wrap2", 16'h0001, 16'h1000, 16'h0001, 1'b1, 16'd10);

    #1 rst = 1'b1;
    #1;
    chk_ifid("arst", 16'h0000, 16'hB000, 16'h0000, 1'b0, 16'd0);
    chk("arst.rd_en", {15'd0, bus.rd_en}, 16'd0);
    #1 rst = 1'b0;
    step(); chk_ifid("arst.f", 16'h0001, 16'h1000, 16'h0001, 1'b1, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that drives the instruction memory (IM) and registers its output into the IF/ID pipeline register.
- Owns the PC and generates the IM address and read enable.
- Handles stalls from ID, branch/jump redirects from EX, and halt detection.
- Sits directly upstream of IM. Also sits upstream of the decode stage, which consumes instr_IF_ID.
- IM latches on clk low when rd_en is high, so an address presented after a rising edge returns its word before the next rising edge.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'hB000, instruction word injected into IF/ID on flush.
- HLT_OPCODE, 4'hF, value of instr[15:12] that marks a halt instruction.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- stall_IF_ID  input  1  decode requests hold of PC and IF/ID (load-use hazard).
- flow_change_ID_EX  input  1  taken branch/jump/return resolved in EX; redirect PC.
- dst_ID_EX  input  16  redirect target, valid when flow_change_ID_EX=1.
- instr  input  16  instruction word from IM.
- iaddr  output  16  IM address; equals the PC register.
- rd_en  output  1  IM read enable.
- instr_IF_ID  output  16  registered instruction to decode.
- pc_IF_ID  output  16  registered PC+1 of that instruction, for link/branch math.
- valid_IF_ID  output  1  instr_IF_ID is a real fetched instruction (not a bubble).
- halted  output  1  fetch has stopped on a HLT.
- fetch_cnt  output  16  count of instructions delivered to ID (valid_IF_ID rising-edge loads).

Behaviour:
- Reset (async, immediate, also mid-operation):
  - pc=RESET_PC; instr_IF_ID=NOP_INSTR; pc_IF_ID=0; valid_IF_ID=0.
  - State=RUN; halted=0; fetch_cnt=0.
- Address and read enable:
  - iaddr = pc, direct from register, no combinational path from inputs.
  - rd_en = ~stall_IF_ID & (state==RUN) & ~rst.
  - When rd_en is low, IM holds its last word, so instr is stable during a stall.
- States:
  - RUN:
    - Priority, highest first: flow_change_ID_EX > stall_IF_ID > normal.
    - flow_change:
      - pc<=dst_ID_EX; instr_IF_ID<=NOP_INSTR; valid_IF_ID<=0; pc_IF_ID holds.
      - Applies even if stall is asserted; the redirect squashes the younger instruction.
    - stall (no flow_change): pc, instr_IF_ID, pc_IF_ID, valid_IF_ID all hold.
    - normal:
      - instr_IF_ID<=instr; pc_IF_ID<=pc+1; valid_IF_ID<=1; fetch_cnt<=fetch_cnt+1.
      - If instr[15:12]==HLT_OPCODE: pc holds and next state=HALTED. The HLT itself is passed to ID.
      - Otherwise pc<=pc+1.
  - HALTED:
    - halted=1; rd_en=0.
    - Normal cycle: instr_IF_ID<=NOP_INSTR; valid_IF_ID<=0; pc holds.
    - Stall: IF/ID holds.
    - flow_change (HLT was in a branch shadow and is squashed): pc<=dst_ID_EX; instr_IF_ID<=NOP_INSTR; valid_IF_ID<=0; next state=RUN.
    - Only reset or flow_change leaves HALTED.
- Arithmetic:
  - pc+1 is 16-bit modulo: 16'hFFFF -> 16'h0000 with no flag.
  - fetch_cnt is 16-bit, wraps 16'hFFFF -> 0.
- Latency: address is presented in cycle N; its instruction appears on instr_IF_ID after rising edge N+1.
- Redirect penalty: exactly one bubble; the next valid_IF_ID=1 appears two edges after flow_change.
- First cycle after reset deassertion: IM returns mem[RESET_PC] before the first edge, so valid_IF_ID=1 after that first edge.

Test Plan:
- Reset, then run with IM words 0x1000..0x1004 at addresses 0..4 and no stall/flow -> iaddr 0,1,2,3; instr_IF_ID 0x1000,0x1001,… one per cycle; pc_IF_ID 1,2,3; fetch_cnt increments each cycle.
- Stall asserted 2 cycles while pc=3 -> iaddr stays 3; rd_en=0; instr_IF_ID/pc_IF_ID/valid unchanged; after release, resumes with mem[3] and no skipped or duplicated word.
- flow_change=1, dst=0x0040, together with stall=1 -> next edge pc=0x0040, instr_IF_ID=0xB000, valid=0; following edge instr_IF_ID=mem[0x40], pc_IF_ID=0x0041.
- mem[5]=0xF000 -> after fetch, pc holds at 5, halted=1, rd_en=0; subsequent IF/ID contents NOP with valid=0; fetch_cnt frozen.
- In HALTED, flow_change with dst=0x0010 -> state RUN, halted=0, pc=0x0010, fetch resumes at mem[0x10].
- pc forced to 0xFFFF via redirect -> next pc=0x0000 and pc_IF_ID=0x0000. Separately, rst asserted mid-run for half a cycle -> outputs return to reset values immediately (async), without waiting for a clock edge.
